// File: rtl/utlb_frontend.sv
// Per-port micro-TLB: serves hits and kseg0/kseg1 in one cycle, walks the shared
// combinational TLB lookup on a miss, refills, and flags translation faults.
package utlb_pkg;
    typedef struct packed {
        logic        miss;
        logic        valid;
        logic        dirty;
        logic        g;
        logic [19:0] pfn;
        logic [2:0]  c;
    } tlb_result_t;
endpackage

module utlb_frontend
    import utlb_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_vaddr,
    input  logic [7:0]  req_asid,
    input  logic        req_store,
    output logic        resp_valid,
    output logic [31:0] resp_paddr,
    output logic        resp_uncached,
    output logic        resp_refill,
    output logic        resp_invalid,
    output logic        resp_modified,
    output logic [31:0] tlb_vaddr,
    output logic [7:0]  tlb_asid,
    input  tlb_result_t tlb_result
);

    localparam int IW = $clog2(ENTRIES);

    typedef enum logic [1:0] {IDLE, WALK, FILL} state_t;

    state_t state, state_nxt;

    logic [ENTRIES-1:0] ent_v;
    logic [19:0]        ent_vpn  [ENTRIES];
    logic [7:0]         ent_asid [ENTRIES];
    logic               ent_g    [ENTRIES];
    logic [19:0]        ent_pfn  [ENTRIES];
    logic [2:0]         ent_c    [ENTRIES];
    logic               ent_d    [ENTRIES];
    logic [IW-1:0]      ptr;

    logic               pend_p0;
    logic [31:0]        vaddr_p0;
    logic [7:0]         asid_p0;
    logic               store_p0;
    tlb_result_t        res_p1;

    logic               hit;
    logic [IW-1:0]      hit_idx;
    logic               unmapped_p0;
    logic               pend_miss;
    logic               victim_free;
    logic [IW-1:0]      victim;
    logic               do_fill;
    logic               accept;

    function automatic logic [31:0] kseg_paddr(input logic [31:0] va);
        return {3'b000, va[28:0]};
    endfunction

    assign tlb_vaddr   = vaddr_p0;
    assign tlb_asid    = asid_p0;
    assign unmapped_p0 = (vaddr_p0[31:30] == 2'b10);
    assign pend_miss   = pend_p0 && !unmapped_p0 && !hit;
    assign accept      = req_valid && req_ready;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_v[i] && ent_vpn[i] == vaddr_p0[31:12] &&
                (ent_g[i] || ent_asid[i] == asid_p0)) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Lowest-numbered free slot wins; only when all are valid does the round-robin pointer pick.
    always_comb begin
        victim_free = 1'b0;
        victim      = ptr;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!ent_v[i]) begin
                victim_free = 1'b1;
                victim      = IW'(i);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_paddr    = '0;
        resp_uncached = 1'b0;
        resp_refill   = 1'b0;
        resp_invalid  = 1'b0;
        resp_modified = 1'b0;
        do_fill       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !flush && !pend_miss;
                if (pend_p0 && !flush) begin
                    if (unmapped_p0) begin
                        resp_valid    = 1'b1;
                        resp_paddr    = kseg_paddr(vaddr_p0);
                        resp_uncached = vaddr_p0[29];
                    end else if (hit) begin
                        resp_valid    = 1'b1;
                        resp_paddr    = {ent_pfn[hit_idx], vaddr_p0[11:0]};
                        resp_uncached = (ent_c[hit_idx] == 3'd2);
                        resp_modified = store_p0 && !ent_d[hit_idx];
                    end else begin
                        state_nxt = WALK;
                    end
                end
            end
            WALK: begin
                state_nxt = flush ? IDLE : FILL;
            end
            FILL: begin
                state_nxt = IDLE;
                if (!flush) begin
                    resp_valid = 1'b1;
                    if (res_p1.miss) begin
                        resp_refill = 1'b1;
                    end else begin
                        resp_paddr    = {res_p1.pfn, vaddr_p0[11:0]};
                        resp_uncached = (res_p1.c == 3'd2);
                        if (!res_p1.valid) begin
                            resp_invalid = 1'b1;
                        end else begin
                            do_fill       = 1'b1;
                            resp_modified = store_p0 && !res_p1.dirty;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: accepted request and control state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pend_p0  <= 1'b0;
            vaddr_p0 <= '0;
            asid_p0  <= '0;
            store_p0 <= 1'b0;
            ent_v    <= '0;
            ptr      <= '0;
        end else begin
            state   <= state_nxt;
            pend_p0 <= accept;
            if (accept) begin
                vaddr_p0 <= req_vaddr;
                asid_p0  <= req_asid;
                store_p0 <= req_store;
            end
            if (flush) begin
                ent_v <= '0;
            end else if (do_fill) begin
                ent_v[victim] <= 1'b1;
                if (!victim_free) begin
                    ptr <= ptr + IW'(1);
                end
            end
        end
    end

    // Stage p1: sampled shared-TLB result and entry payload
    always_ff @(posedge clk) begin
        if (state == WALK) begin
            res_p1 <= tlb_result;
        end
        if (do_fill) begin
            ent_vpn[victim]  <= vaddr_p0[31:12];
            ent_asid[victim] <= asid_p0;
            ent_g[victim]    <= res_p1.g;
            ent_pfn[victim]  <= res_p1.pfn;
            ent_c[victim]    <= res_p1.c;
            ent_d[victim]    <= res_p1.dirty;
        end
    end

endmodule

// File: tb/tb_utlb_frontend.sv
// Randomized scoreboard bench for utlb_frontend against a behavioural micro-TLB
// model and a small table-driven shared TLB.
module tb_utlb_frontend;
    import utlb_pkg::*;

    localparam int ENTRIES = 4;
    localparam int NPG     = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic [7:0]  req_asid;
    logic        req_store;
    logic        resp_valid;
    logic [31:0] resp_paddr;
    logic        resp_uncached;
    logic        resp_refill;
    logic        resp_invalid;
    logic        resp_modified;
    logic [31:0] tlb_vaddr;
    logic [7:0]  tlb_asid;
    tlb_result_t tlb_result;

    always #5 clk = ~clk;

    utlb_frontend #(.ENTRIES(ENTRIES)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_vaddr(req_vaddr), .req_asid(req_asid), .req_store(req_store),
        .resp_valid(resp_valid), .resp_paddr(resp_paddr),
        .resp_uncached(resp_uncached), .resp_refill(resp_refill),
        .resp_invalid(resp_invalid), .resp_modified(resp_modified),
        .tlb_vaddr(tlb_vaddr), .tlb_asid(tlb_asid), .tlb_result(tlb_result)
    );

    typedef struct packed {
        logic [19:0] vpn;
        logic [7:0]  asid;
        logic        g;
        logic        v;
        logic        d;
        logic [19:0] pfn;
        logic [2:0]  c;
    } page_t;

    typedef struct {
        logic [31:0] paddr;
        logic        unc;
        logic        refill;
        logic        inval;
        logic        modif;
        int          acc;
        int          lat;
        bit          used_ptr;
    } exp_t;

    function automatic page_t page(input int i);
        case (i)
            0:       return '{20'h00400, 8'd5, 1'b0, 1'b1, 1'b1, 20'h12345, 3'd3};
            1:       return '{20'h00401, 8'd5, 1'b0, 1'b1, 1'b0, 20'h00abc, 3'd3};
            2:       return '{20'h00402, 8'd5, 1'b0, 1'b0, 1'b1, 20'h00def, 3'd3};
            3:       return '{20'h00403, 8'd9, 1'b1, 1'b1, 1'b1, 20'h0babe, 3'd2};
            4:       return '{20'h00404, 8'd6, 1'b0, 1'b1, 1'b1, 20'h01111, 3'd3};
            5:       return '{20'h00405, 8'd5, 1'b0, 1'b1, 1'b1, 20'h02222, 3'd3};
            6:       return '{20'h7ff00, 8'd5, 1'b0, 1'b1, 1'b1, 20'h03333, 3'd3};
            7:       return '{20'hc0000, 8'd6, 1'b0, 1'b1, 1'b0, 20'h04444, 3'd2};
            default: return '{20'h00406, 8'd5, 1'b0, 1'b1, 1'b1, 20'h05555, 3'd3};
        endcase
    endfunction

    function automatic tlb_result_t shared_lookup(input logic [31:0] va, input logic [7:0] as);
        tlb_result_t r;
        page_t p;
        r = '0;
        r.miss = 1'b1;
        for (int i = 0; i < NPG; i++) begin
            p = page(i);
            if (r.miss && p.vpn == va[31:12] && (p.g || p.asid == as)) begin
                r.miss  = 1'b0;
                r.valid = p.v;
                r.dirty = p.d;
                r.g     = p.g;
                r.pfn   = p.pfn;
                r.c     = p.c;
            end
        end
        return r;
    endfunction

    always_comb tlb_result = shared_lookup(tlb_vaddr, tlb_asid);

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    bit          m_v    [ENTRIES];
    logic [19:0] m_vpn  [ENTRIES];
    logic [7:0]  m_asid [ENTRIES];
    bit          m_g    [ENTRIES];
    logic [19:0] m_pfn  [ENTRIES];
    logic [2:0]  m_c    [ENTRIES];
    bit          m_d    [ENTRIES];
    int          m_ptr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic predict(input logic [31:0] va, input logic [7:0] as, input logic st, output exp_t e);
        int h;
        int slot;
        tlb_result_t r;
        e.paddr = '0; e.unc = 0; e.refill = 0; e.inval = 0; e.modif = 0;
        e.acc = 0; e.lat = 1; e.used_ptr = 0;
        if (va[31:30] == 2'b10) begin
            e.paddr = {3'b000, va[28:0]};
            e.unc   = va[29];
            return;
        end
        h = -1;
        for (int i = 0; i < ENTRIES; i++)
            if (m_v[i] && m_vpn[i] == va[31:12] && (m_g[i] || m_asid[i] == as)) h = i;
        if (h >= 0) begin
            e.paddr = {m_pfn[h], va[11:0]};
            e.unc   = (m_c[h] == 3'd2);
            e.modif = st && !m_d[h];
            return;
        end
        e.lat = 3;
        r = shared_lookup(va, as);
        if (r.miss) begin
            e.refill = 1;
            return;
        end
        e.paddr = {r.pfn, va[11:0]};
        e.unc   = (r.c == 3'd2);
        if (!r.valid) begin
            e.inval = 1;
            return;
        end
        e.modif = st && !r.dirty;
        slot = -1;
        for (int i = 0; i < ENTRIES; i++)
            if (!m_v[i] && slot < 0) slot = i;
        if (slot < 0) begin
            slot = m_ptr;
            m_ptr = (m_ptr + 1) % ENTRIES;
            e.used_ptr = 1;
        end
        m_v[slot] = 1; m_vpn[slot] = va[31:12]; m_asid[slot] = as;
        m_g[slot] = r.g; m_pfn[slot] = r.pfn; m_c[slot] = r.c; m_d[slot] = r.dirty;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] va, input logic [7:0] as, input logic st);
        int   waited;
        exp_t e;
        waited = 0;
        req_valid = 1'b1; req_vaddr = va; req_asid = as; req_store = st;
        #1;
        while (!req_ready && waited < 20) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready stayed 0 for vaddr %h", va);
            req_valid = 1'b0;
            tick(1);
            return;
        end
        predict(va, as, st, e);
        e.acc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_flush();
        int   f;
        exp_t l;
        req_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("ready_in_flush", {31'b0, req_ready}, 32'd0);
        f = cyc;
        if (sb.size() > 0) begin
            l = sb[$];
            if (l.acc + l.lat >= f) begin
                if (l.used_ptr) m_ptr = (m_ptr + ENTRIES - 1) % ENTRIES;
                void'(sb.pop_back());
            end
        end
        for (int i = 0; i < ENTRIES; i++) m_v[i] = 0;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: paddr %h at cycle %0d, none expected", resp_paddr, cyc);
            end else begin
                e = sb.pop_front();
                chk("resp_paddr", resp_paddr, e.paddr);
                chk("resp_flags{unc,refill,inv,mod}",
                    {28'b0, resp_uncached, resp_refill, resp_invalid, resp_modified},
                    {28'b0, e.unc, e.refill, e.inval, e.modif});
                chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] va;
        logic [7:0]  as;
        int          k;
        int          r;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0;
        req_vaddr = '0; req_asid = '0; req_store = 1'b0;
        for (int i = 0; i < ENTRIES; i++) m_v[i] = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_resp", {26'b0, resp_valid, resp_uncached, resp_refill, resp_invalid, resp_modified, 1'b0}, 32'd0);
        chk("reset_resp_paddr", resp_paddr, 32'd0);
        chk("reset_tlb_vaddr", tlb_vaddr, 32'd0);
        chk("reset_tlb_asid", {24'b0, tlb_asid}, 32'd0);
        rst = 1'b0;
        tick(1);

        issue(32'h8000_1234, 8'd5, 1'b0);
        issue(32'hA000_0010, 8'd5, 1'b0);
        issue(32'h0040_0abc, 8'd5, 1'b0);
        issue(32'h0040_0abc, 8'd5, 1'b0);
        issue(32'h0060_0000, 8'd5, 1'b0);
        issue(32'h0060_0000, 8'd5, 1'b0);
        issue(32'h0040_1000, 8'd5, 1'b1);
        issue(32'h0040_1004, 8'd5, 1'b1);
        issue(32'h0040_2008, 8'd5, 1'b0);
        issue(32'h0040_2008, 8'd5, 1'b0);
        tick(2);

        do_flush();
        issue(32'h0040_0000, 8'd5, 1'b0);
        issue(32'h0040_1010, 8'd5, 1'b0);
        issue(32'h0040_3020, 8'd5, 1'b0);
        issue(32'h0040_5030, 8'd5, 1'b0);
        issue(32'h7ff0_0040, 8'd5, 1'b0);
        issue(32'h0040_6050, 8'd5, 1'b0);
        tick(1);
        do_flush();
        issue(32'h0040_1010, 8'd5, 1'b0);
        tick(3);

        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                do_flush();
            end else if (r < 7) begin
                tick(1);
                do_flush();
            end else begin
                if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
                k = $urandom_range(0, 11);
                if (k < NPG)       va = {page(k).vpn, 12'($urandom)};
                else if (k == 9)   va = {3'b100, 29'($urandom)};
                else if (k == 10)  va = {3'b101, 29'($urandom)};
                else               va = {20'h00600, 12'($urandom)};
                as = ($urandom_range(0, 1) == 0) ? 8'd5 : 8'd6;
                issue(va, as, 1'($urandom_range(0, 1)));
            end
        end

        tick(6);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
